// File: rtl/sample_interp_pkg.sv
// Shared types and sizing helpers for the sample interpolator.
package sample_interp_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Accumulator holds a 17-bit delta scaled by 2**rate_log2.
  function automatic int unsigned acc_width(input int unsigned rate_log2);
    return SAMPLE_W + 1 + rate_log2;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with a zero-latency head output.
module sample_fifo
  import sample_interp_pkg::*;
#(
  parameter int unsigned FIFO_LOG2 = 2
) (
  input  logic                i_clk,
  input  logic                i_res,
  input  logic                push,
  input  logic                pop,
  input  logic [SAMPLE_W-1:0] din,
  output logic [SAMPLE_W-1:0] dout,
  output logic                full,
  output logic                empty
);

  localparam int unsigned Depth = 2 ** FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] DepthCnt = (FIFO_LOG2 + 1)'(Depth);

  logic [SAMPLE_W-1:0]  mem_q [Depth];
  logic [FIFO_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_LOG2:0]   count_q, count_d;
  logic                 push_ok, pop_ok;

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sample_interpolator.sv
// Linear interpolator feeding the sigma-delta DAC: one new sample per 2**RATE_LOG2 clocks.
// Optional o_underrun_cnt port is enabled by defining SAMPLE_INTERP_UNDERRUN_CNT_EN.
module sample_interpolator
  import sample_interp_pkg::*;
#(
  parameter int unsigned RATE_LOG2 = 4,
  parameter int unsigned FIFO_LOG2 = 2
) (
  input  logic                i_clk,
  input  logic                i_res,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [SAMPLE_W-1:0] o_func,
  output logic                o_tick,
  output logic                o_underrun
`ifdef SAMPLE_INTERP_UNDERRUN_CNT_EN
  ,
  output logic [15:0]         o_underrun_cnt
`endif
);

  localparam int unsigned AccW = acc_width(RATE_LOG2);

  logic [RATE_LOG2-1:0]       phase_q;
  sample_t                    curr_q, curr_d, new_s;
  logic signed [SAMPLE_W:0]   delta_q, delta_d;
  logic signed [AccW-1:0]     acc_q, acc_d;
  logic                       tick, fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0]        fifo_dout;
  logic                       unused_acc;

  assign tick       = &phase_q;
  assign o_ready    = ~fifo_full;
  assign o_tick     = tick;
  assign o_underrun = tick & fifo_empty;

  sample_fifo #(
    .FIFO_LOG2(FIFO_LOG2)
  ) u_fifo (
    .i_clk (i_clk),
    .i_res (i_res),
    .push  (i_valid & ~fifo_full),
    .pop   (tick & ~fifo_empty),
    .din   (i_sample),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // On underrun the current value is repeated, giving a flat segment.
  always_comb begin
    new_s   = fifo_empty ? curr_q : sample_t'(fifo_dout);
    curr_d  = curr_q;
    delta_d = delta_q;
    acc_d   = acc_q + {{RATE_LOG2{delta_q[SAMPLE_W]}}, delta_q};
    if (tick) begin
      curr_d  = new_s;
      delta_d = {new_s[SAMPLE_W-1], new_s} - {curr_q[SAMPLE_W-1], curr_q};
      acc_d   = {curr_q[SAMPLE_W-1], curr_q, {RATE_LOG2{1'b0}}};
    end
  end

  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      phase_q <= '0;
      curr_q  <= '0;
      delta_q <= '0;
      acc_q   <= '0;
    end else begin
      phase_q <= phase_q + 1'b1;
      curr_q  <= curr_d;
      delta_q <= delta_d;
      acc_q   <= acc_d;
    end
  end

  // acc stays between old and new sample, so this slice cannot overflow.
  assign o_func     = acc_q[RATE_LOG2 +: SAMPLE_W];
  assign unused_acc = ^{acc_q[AccW-1], acc_q[RATE_LOG2-1:0]};

`ifdef SAMPLE_INTERP_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;

  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      ucnt_q <= '0;
    end else if (o_underrun && (ucnt_q != 16'hFFFF)) begin
      ucnt_q <= ucnt_q + 16'd1;
    end
  end

  assign o_underrun_cnt = ucnt_q;
`endif

endmodule
